child_response_collector: RTL and testbench

- Fan-in counterpart to the root-level fan-out hierarchy: gathers response words from NUM_CHILD child instances back toward the root.
- Each child presents data over a valid/ready handshake.
- A round-robin arbiter selects one child per cycle into a single registered output stage. Each output word is tagged with the source child index.
- Tracks per-round completion (every child delivered at least once) and can optionally act as a barrier.

---
 rtl/child_response_collector_if.sv | 59 +++++
 rtl/child_response_collector.sv | 158 +++++++++++++++
 tb/tb_child_response_collector.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/child_response_collector_if.sv
// -----------------------------------------------------------------------------
// child_response_collector_if
// Bundles the child-side response handshakes and the single output stage of
// the child response collector.
//
// Signals:
//   ch_valid   [NUM_CHILD]         per-child data valid (child -> collector)
//   ch_ready   [NUM_CHILD]         per-child accept, one-hot or zero
//   ch_data    [NUM_CHILD*DATA_W]  child i occupies [i*DATA_W +: DATA_W]
//   out_valid                      output register holds a word
//   out_ready                      downstream accept
//   out_data   [DATA_W]            registered word
//   out_idx    [IDX_W]             source child of out_data
//   round_seen [NUM_CHILD]         children delivered in the current round
//   round_done                     one-cycle pulse when a round completes
//
// Modports:
//   slave  - the collector itself
//   master - the environment (children plus downstream consumer)
// -----------------------------------------------------------------------------
interface child_response_collector_if #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = $clog2(NUM_CHILD)
);
  logic [NUM_CHILD-1:0]        ch_valid;
  logic [NUM_CHILD-1:0]        ch_ready;
  logic [NUM_CHILD*DATA_W-1:0] ch_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W-1:0]           out_data;
  logic [IDX_W-1:0]            out_idx;
  logic [NUM_CHILD-1:0]        round_seen;
  logic                        round_done;

  modport slave (
    input  ch_valid,
    input  ch_data,
    input  out_ready,
    output ch_ready,
    output out_valid,
    output out_data,
    output out_idx,
    output round_seen,
    output round_done
  );

  modport master (
    output ch_valid,
    output ch_data,
    output out_ready,
    input  ch_ready,
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  round_seen,
    input  round_done
  );
endinterface

// File: rtl/child_response_collector.sv
// -----------------------------------------------------------------------------
// child_response_collector
// Fan-in of NUM_CHILD child response channels into one registered output
// stage. A round-robin arbiter picks at most one child per cycle; each output
// word carries the index of the child it came from. A round completes once
// every child has delivered at least once; with BARRIER=1 a child that has
// already delivered in the current round is held off until the round ends.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - child_response_collector_if.slave (child handshakes, output
//            stage, round tracking)
// -----------------------------------------------------------------------------
module child_response_collector #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = $clog2(NUM_CHILD),
  parameter bit BARRIER   = 1'b0
) (
  input logic                      clk,
  input logic                      rst_n,
  child_response_collector_if.slave bus
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam int                   CW       = IDX_W + 1;
  localparam logic [CW-1:0]        NUM_W    = CW'(NUM_CHILD);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CHILD - 1);
  localparam logic [NUM_CHILD-1:0] ALL_SEEN = {NUM_CHILD{1'b1}};

  logic                 out_valid_r;
  logic [DATA_W-1:0]    out_data_r;
  logic [IDX_W-1:0]     out_idx_r;
  logic [IDX_W-1:0]     ptr_r;
  logic [NUM_CHILD-1:0] round_seen_r;
  logic                 round_done_r;

  logic [NUM_CHILD-1:0] eligible_s;
  logic [CW-1:0]        cand_s;
  logic                 found_s;
  logic [IDX_W-1:0]     grant_s;
  logic [DATA_W-1:0]    grant_data_s;
  logic                 can_accept_s;
  logic                 accept_s;
  logic [NUM_CHILD-1:0] onehot_s;
  logic [NUM_CHILD-1:0] ch_ready_s;
  logic [NUM_CHILD-1:0] seen_next_s;
  logic                 round_full_s;
  logic [IDX_W-1:0]     ptr_next_s;

  // Candidates for arbitration; the barrier masks children already seen.
  always_comb begin
    eligible_s = bus.ch_valid;
    if (BARRIER) begin
      eligible_s = bus.ch_valid & ~round_seen_r;
    end else begin
      eligible_s = bus.ch_valid;
    end
  end

  // Round-robin search: first eligible child at or after ptr, wrapping
  // explicitly modulo NUM_CHILD so non-power-of-two counts never yield
  // an unused index code.
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    cand_s  = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      cand_s = {1'b0, ptr_r} + CW'(k);
      if (cand_s >= NUM_W) begin
        cand_s = cand_s - NUM_W;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && eligible_s[cand_s[IDX_W-1:0]]) begin
        found_s = 1'b1;
        grant_s = cand_s[IDX_W-1:0];
      end else begin
        found_s = found_s;
        grant_s = grant_s;
      end
    end
  end

  // Select the granted child's data word.
  always_comb begin
    grant_data_s = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      if (IDX_W'(k) == grant_s) begin
        grant_data_s = bus.ch_data[k*DATA_W +: DATA_W];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // Handshake, round bookkeeping and next pointer for the granted child.
  always_comb begin
    can_accept_s = !out_valid_r || bus.out_ready;
    accept_s     = can_accept_s && found_s;
    onehot_s     = '0;
    onehot_s[grant_s] = 1'b1;
    if (accept_s) begin
      ch_ready_s = onehot_s;
    end else begin
      ch_ready_s = '0;
    end
    seen_next_s  = round_seen_r | onehot_s;
    round_full_s = (seen_next_s == ALL_SEEN);
    if (grant_s == LAST_IDX) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_s + IDX_W'(1);
    end
  end

  // Output register, rotation pointer and round tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_idx_r    <= '0;
      ptr_r        <= '0;
      round_seen_r <= '0;
      round_done_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= grant_data_s;
      out_idx_r   <= grant_s;
      ptr_r       <= ptr_next_s;
      if (round_full_s) begin
        round_seen_r <= '0;
        round_done_r <= 1'b1;
      end else begin
        round_seen_r <= seen_next_s;
        round_done_r <= 1'b0;
      end
    end else begin
      // Nothing granted: a drained word empties the stage, a stalled
      // word holds along with the pointer.
      if (can_accept_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      round_done_r <= 1'b0;
    end
  end

  assign bus.ch_ready   = ch_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_idx    = out_idx_r;
  assign bus.round_seen = round_seen_r;
  assign bus.round_done = round_done_r;

endmodule

// File: tb/tb_child_response_collector.sv
// -----------------------------------------------------------------------------
// tb_child_response_collector
// Drives two collectors (BARRIER=0 and BARRIER=1) and compares every output
// against a behavioural reference model each cycle: directed scenarios first,
// then randomized traffic and an asynchronous reset in mid-round.
// -----------------------------------------------------------------------------
module tb_child_response_collector;
  localparam int NC = 5;
  localparam int DW = 8;
  localparam int IW = $clog2(NC);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC-1:0]    tv_valid [2];
  logic [NC*DW-1:0] tv_data  [2];
  logic             tv_ready [2];

  logic [NC-1:0] o_ready [2];
  logic          o_valid [2];
  logic [DW-1:0] o_data  [2];
  logic [IW-1:0] o_idx   [2];
  logic [NC-1:0] o_seen  [2];
  logic          o_done  [2];

  child_response_collector_if #(.NUM_CHILD(NC), .DATA_W(DW)) bus0 ();
  child_response_collector_if #(.NUM_CHILD(NC), .DATA_W(DW)) bus1 ();

  assign bus0.ch_valid  = tv_valid[0];
  assign bus0.ch_data   = tv_data[0];
  assign bus0.out_ready = tv_ready[0];
  assign bus1.ch_valid  = tv_valid[1];
  assign bus1.ch_data   = tv_data[1];
  assign bus1.out_ready = tv_ready[1];

  assign o_ready[0] = bus0.ch_ready;
  assign o_valid[0] = bus0.out_valid;
  assign o_data[0]  = bus0.out_data;
  assign o_idx[0]   = bus0.out_idx;
  assign o_seen[0]  = bus0.round_seen;
  assign o_done[0]  = bus0.round_done;
  assign o_ready[1] = bus1.ch_ready;
  assign o_valid[1] = bus1.out_valid;
  assign o_data[1]  = bus1.out_data;
  assign o_idx[1]   = bus1.out_idx;
  assign o_seen[1]  = bus1.round_seen;
  assign o_done[1]  = bus1.round_done;

  child_response_collector #(.NUM_CHILD(NC), .DATA_W(DW), .BARRIER(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  child_response_collector #(.NUM_CHILD(NC), .DATA_W(DW), .BARRIER(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state: what the registered outputs should show now.
  int m_valid [2];
  int m_data  [2];
  int m_idx   [2];
  int m_ptr   [2];
  int m_seen  [2];
  int m_done  [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int b = 0; b < 2; b++) begin
      m_valid[b] = 0;
      m_data[b]  = 0;
      m_idx[b]   = 0;
      m_ptr[b]   = 0;
      m_seen[b]  = 0;
      m_done[b]  = 0;
    end
  endfunction

  // Child picked by round-robin from m_ptr, or -1 if none may deliver.
  function automatic int m_pick(int b);
    int cand;
    cand = int'(tv_valid[b]);
    if (b == 1) cand = cand & ~m_seen[b];
    for (int k = 0; k < NC; k++) begin
      int i;
      i = (m_ptr[b] + k) % NC;
      if (((cand >> i) & 1) == 1) return i;
    end
    return -1;
  endfunction

  // Called at a negedge with inputs applied; checks, advances model to the
  // state after the coming posedge, returns at the next negedge.
  task automatic cycle();
    #1;
    for (int b = 0; b < 2; b++) begin
      int g;
      int can;
      int exp_rdy;
      g   = m_pick(b);
      can = (m_valid[b] == 0 || tv_ready[b] == 1'b1) ? 1 : 0;
      exp_rdy = (can == 1 && g >= 0) ? (1 << g) : 0;
      check_eq($sformatf("ch_ready[d%0d]", b),   32'(o_ready[b]), exp_rdy);
      check_eq($sformatf("out_valid[d%0d]", b),  32'(o_valid[b]), m_valid[b]);
      if (m_valid[b] != 0) begin
        check_eq($sformatf("out_data[d%0d]", b), 32'(o_data[b]),  m_data[b]);
        check_eq($sformatf("out_idx[d%0d]", b),  32'(o_idx[b]),   m_idx[b]);
      end
      check_eq($sformatf("round_seen[d%0d]", b), 32'(o_seen[b]),  m_seen[b]);
      check_eq($sformatf("round_done[d%0d]", b), 32'(o_done[b]),  m_done[b]);
      if (can == 1 && g >= 0) begin
        m_valid[b] = 1;
        m_data[b]  = int'((tv_data[b] >> (g * DW)) & 40'hFF);
        m_idx[b]   = g;
        m_ptr[b]   = (g + 1) % NC;
        m_seen[b]  = m_seen[b] | (1 << g);
        if ($countones(m_seen[b]) == NC) begin
          m_seen[b] = 0;
          m_done[b] = 1;
        end else begin
          m_done[b] = 0;
        end
      end else begin
        if (can == 1) m_valid[b] = 0;
        m_done[b] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_all(input logic [NC-1:0] v, input logic [NC*DW-1:0] d, input logic r);
    for (int b = 0; b < 2; b++) begin
      tv_valid[b] = v;
      tv_data[b]  = d;
      tv_ready[b] = r;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_all('0, '0, 1'b0);
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [NC*DW-1:0] ramp;

  initial begin
    for (int i = 0; i < NC; i++) ramp[i*DW +: DW] = DW'(i * 8'h11);

    do_reset();
    // Reset state (cycle also checks ch_ready with all children idle).
    cycle();

    // Every child valid, full throughput: 0,1,2,3,4,0,... and a round pulse.
    set_all({NC{1'b1}}, ramp, 1'b1);
    repeat (12) cycle();

    // Only child 3: repeats forwarded without a barrier, held off with one.
    do_reset();
    set_all(5'b01000, ramp, 1'b1);
    repeat (5) cycle();

    // Barrier scenario: children 1 and 2, then 0, 3 and 4 join.
    do_reset();
    set_all(5'b00110, ramp, 1'b1);
    repeat (4) cycle();
    set_all(5'b11111, ramp, 1'b1);
    repeat (6) cycle();

    // Output stall with a word held, then release with no bubble.
    do_reset();
    set_all(5'b11111, 40'hA5A5A5A5A5, 1'b1);
    repeat (3) cycle();
    set_all(5'b11111, 40'h1122334455, 1'b0);
    repeat (6) cycle();
    set_all(5'b11111, 40'h1122334455, 1'b1);
    repeat (3) cycle();

    // Drain with all children idle; pointer must survive.
    set_all('0, '0, 1'b1);
    repeat (3) cycle();
    set_all(5'b11111, ramp, 1'b1);
    repeat (3) cycle();

    // Randomized traffic, independent per collector.
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 3) == 0) tv_valid[b] = NC'($urandom());
        else tv_valid[b] = NC'($urandom() | $urandom());
        tv_data[b]  = {$urandom(), 8'($urandom())};
        tv_ready[b] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end

    // Asynchronous reset in mid-round with a word held.
    do_reset();
    set_all(5'b00111, ramp, 1'b0);
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    for (int b = 0; b < 2; b++) begin
      check_eq($sformatf("async out_valid[d%0d]", b), 32'(o_valid[b]), 32'd0);
      check_eq($sformatf("async out_data[d%0d]", b),  32'(o_data[b]),  32'd0);
      check_eq($sformatf("async out_idx[d%0d]", b),   32'(o_idx[b]),   32'd0);
      check_eq($sformatf("async round_seen[d%0d]", b), 32'(o_seen[b]), 32'd0);
      check_eq($sformatf("async round_done[d%0d]", b), 32'(o_done[b]), 32'd0);
    end
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_all(5'b11111, ramp, 1'b1);
    repeat (6) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
